// File: rtl/wb_mem_arbiter_pkg.sv
// Shared types and bus geometry for the two-master RAM arbiter.
package wb_arb_pkg;

  localparam int unsigned WB_ADDR_W = 32;
  localparam int unsigned WB_DATA_W = 32;

  typedef enum logic [1:0] {IDLE, GNT_M0, GNT_M1, RELEASE} arb_state_t;
  typedef enum logic {M0 = 1'b0, M1 = 1'b1} master_id_t;

  // One-hot grant encoding {M1,M0}
  localparam logic [1:0] GRANT_NONE = 2'b00;
  localparam logic [1:0] GRANT_M0   = 2'b01;
  localparam logic [1:0] GRANT_M1   = 2'b10;

endpackage

// File: rtl/wb_mem_arbiter_if.sv
// Wishbone point-to-point bundle used by the core masters and the RAM block.
interface WISHBONE_IF;
  import wb_arb_pkg::*;

  logic                 iClk;
  logic                 iRst;
  logic                 stb;
  logic                 cyc;
  logic                 we;
  logic [WB_ADDR_W-1:0] addr;
  logic [1:0]           width;       // 00 byte, 01 half, 1x word
  logic [WB_DATA_W-1:0] data_write;
  logic [WB_DATA_W-1:0] data_read;
  logic                 ack;

  modport master (
    output iClk, iRst, stb, cyc, we, addr, width, data_write,
    input  data_read, ack
  );

  modport slave (
    input  iClk, iRst, stb, cyc, we, addr, width, data_write,
    output data_read, ack
  );

endinterface

// File: rtl/wb_mem_arbiter_mux.sv
// Combinational request/response steering between two masters and the RAM.
// The non-granted master always sees ack=0 and data_read=0.
module wb_arb_mux
  import wb_arb_pkg::*;
(
  input  logic [1:0]  grant,
  WISHBONE_IF.slave   m0_wb,
  WISHBONE_IF.slave   m1_wb,
  WISHBONE_IF.master  s_wb
);

  // Route the owner's request forward and the RAM response back to it only
  always_comb begin
    s_wb.stb        = 1'b0;
    s_wb.cyc        = 1'b0;
    s_wb.we         = 1'b0;
    s_wb.addr       = '0;
    s_wb.width      = '0;
    s_wb.data_write = '0;
    m0_wb.ack       = 1'b0;
    m0_wb.data_read = '0;
    m1_wb.ack       = 1'b0;
    m1_wb.data_read = '0;
    case (grant)
      GRANT_M0: begin
        s_wb.stb        = m0_wb.stb;
        s_wb.cyc        = m0_wb.cyc;
        s_wb.we         = m0_wb.we;
        s_wb.addr       = m0_wb.addr;
        s_wb.width      = m0_wb.width;
        s_wb.data_write = m0_wb.data_write;
        m0_wb.ack       = s_wb.ack;
        m0_wb.data_read = s_wb.data_read;
      end
      GRANT_M1: begin
        s_wb.stb        = m1_wb.stb;
        s_wb.cyc        = m1_wb.cyc;
        s_wb.we         = m1_wb.we;
        s_wb.addr       = m1_wb.addr;
        s_wb.width      = m1_wb.width;
        s_wb.data_write = m1_wb.data_write;
        m1_wb.ack       = s_wb.ack;
        m1_wb.data_read = s_wb.data_read;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/wb_mem_arbiter.sv
// Round-robin two-master Wishbone arbiter in front of the on-chip RAM.
// Grant is held for a whole master cycle; a dead RELEASE cycle separates
// owners, and a watchdog forces release of a master stalled without ack.
module wb_mem_arbiter
  import wb_arb_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        iClk,
  input  logic        iRst,
  WISHBONE_IF.slave   m0_wb,
  WISHBONE_IF.slave   m1_wb,
  WISHBONE_IF.master  s_wb,
  output logic [1:0]  oGrant,
  output logic        oTimeout
);

  localparam int unsigned     CNT_W     = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] WDOG_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  arb_state_t       state;
  master_id_t       last_grant;
  master_id_t       owner;
  logic [CNT_W-1:0] wdog;

  assign s_wb.iClk = iClk;
  assign s_wb.iRst = iRst;

  // oGrant is a registered copy of the grant state, so it drives the mux directly
  wb_arb_mux u_mux (
    .grant (oGrant),
    .m0_wb (m0_wb),
    .m1_wb (m1_wb),
    .s_wb  (s_wb)
  );

  assign owner = (state == GNT_M1) ? M1 : M0;

  // Arbitration FSM with watchdog; all outputs registered
  always_ff @(posedge iClk) begin
    if (iRst) begin
      state      <= IDLE;
      oGrant     <= GRANT_NONE;
      oTimeout   <= 1'b0;
      wdog       <= '0;
      last_grant <= M1;
    end else begin
      oTimeout <= 1'b0;
      case (state)
        IDLE: begin
          if (m0_wb.cyc && (!m1_wb.cyc || last_grant == M1)) begin
            state  <= GNT_M0;
            oGrant <= GRANT_M0;
            wdog   <= '0;
          end else if (m1_wb.cyc) begin
            state  <= GNT_M1;
            oGrant <= GRANT_M1;
            wdog   <= '0;
          end
        end
        GNT_M0, GNT_M1: begin
          // cyc drop takes precedence; an ack in the same cycle has already
          // reached the master combinationally
          if (!s_wb.cyc) begin
            state      <= RELEASE;
            oGrant     <= GRANT_NONE;
            last_grant <= owner;
            wdog       <= '0;
          end else if (s_wb.ack || !s_wb.stb) begin
            wdog <= '0;
          end else if (wdog == WDOG_LAST) begin
            state      <= RELEASE;
            oGrant     <= GRANT_NONE;
            last_grant <= owner;
            oTimeout   <= 1'b1;
            wdog       <= '0;
          end else begin
            wdog <= wdog + CNT_W'(1);
          end
        end
        RELEASE: begin
          state <= IDLE;
        end
        default: begin
          state  <= IDLE;
          oGrant <= GRANT_NONE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wb_mem_arbiter.sv
// Directed bench for wb_mem_arbiter: single-cycle-ack RAM model, two
// scripted masters, hand-computed expectations.
module tb_wb_mem_arbiter;
  import wb_arb_pkg::*;

  logic       iClk = 1'b0;
  logic       iRst;
  logic [1:0] oGrant;
  logic       oTimeout;
  logic       ack_en;

  int checks = 0;
  int errors = 0;

  WISHBONE_IF m0 ();
  WISHBONE_IF m1 ();
  WISHBONE_IF s ();

  logic [31:0] mem [0:63];

  always #5 iClk = ~iClk;

  assign m0.iClk = iClk;
  assign m0.iRst = iRst;
  assign m1.iClk = iClk;
  assign m1.iRst = iRst;

  wb_mem_arbiter #(.TIMEOUT_CYCLES(16)) dut (
    .iClk     (iClk),
    .iRst     (iRst),
    .m0_wb    (m0),
    .m1_wb    (m1),
    .s_wb     (s),
    .oGrant   (oGrant),
    .oTimeout (oTimeout)
  );

  // RAM model: combinational ack, write on the bus clock
  always_comb begin
    s.ack       = ack_en & s.cyc & s.stb & ~s.iRst;
    s.data_read = (s.ack && !s.we) ? mem[s.addr[7:2]] : 32'd0;
  end

  always @(posedge s.iClk) begin
    if (s.ack && s.we) mem[s.addr[7:2]] <= s.data_write;
  end

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 32'hA000_0000 + i;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge iClk);
    #1;
  endtask

  task automatic smp();
    @(negedge iClk);
  endtask

  task automatic drv(input int id, input logic c, input logic w,
                     input logic [31:0] a, input logic [31:0] d);
    if (id == 0) begin
      m0.cyc = c; m0.stb = c; m0.we = w; m0.addr = a; m0.width = 2'b10; m0.data_write = d;
    end else begin
      m1.cyc = c; m1.stb = c; m1.we = w; m1.addr = a; m1.width = 2'b10; m1.data_write = d;
    end
  endtask

  task automatic idle(input int n);
    drv(0, 1'b0, 1'b0, 32'd0, 32'd0);
    drv(1, 1'b0, 1'b0, 32'd0, 32'd0);
    repeat (n) step();
  endtask

  function automatic logic ack_of(input int id);
    return (id == 0) ? m0.ack : m1.ack;
  endfunction

  function automatic logic [31:0] data_of(input int id);
    return (id == 0) ? m0.data_read : m1.data_read;
  endfunction

  // Single-beat reads: hold cyc until ack, drop for one edge, repeat
  task automatic run_master(input int id, input int n, input logic [31:0] base);
    for (int k = 0; k < n; k++) begin
      int t;
      t = 0;
      drv(id, 1'b1, 1'b0, base + 32'(4 * k), 32'd0);
      do begin
        smp();
        t++;
      end while (!ack_of(id) && t < 64);
      check($sformatf("m%0d beat%0d ack", id, k), ack_of(id), 1);
      check($sformatf("m%0d beat%0d data", id, k), data_of(id), 32'hA000_0000 + (base >> 2) + k);
      step();
      drv(id, 1'b0, 1'b0, 32'd0, 32'd0);
      step();
    end
  endtask

  // Contention monitor: compressed grant history, ack count, idle-side leaks
  logic        mon_en = 1'b0;
  logic [63:0] seq;
  logic [1:0]  prev_g;
  int          n_ack;
  int          bad_idle;

  always @(negedge iClk) begin
    if (mon_en) begin
      if (oGrant !== prev_g) begin
        seq    = {seq[61:0], oGrant};
        prev_g = oGrant;
      end
      if (m0.ack) n_ack++;
      if (m1.ack) n_ack++;
      if (oGrant != 2'b01 && (m0.ack !== 1'b0 || m0.data_read !== 32'd0)) bad_idle++;
      if (oGrant != 2'b10 && (m1.ack !== 1'b0 || m1.data_read !== 32'd0)) bad_idle++;
    end
  end

  initial begin
    #200000;
    $display("FAIL time_limit: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [63:0] exp_seq;
    int          bad;

    iRst   = 1'b1;
    ack_en = 1'b1;
    // 1: reset with both masters requesting
    drv(0, 1'b1, 1'b0, 32'h0, 32'd0);
    drv(1, 1'b1, 1'b0, 32'h4, 32'd0);
    step(); smp();
    check("rst_grant", oGrant, 2'b00);
    check("rst_scyc", s.cyc, 0);
    check("rst_acks", {m0.ack, m1.ack}, 2'b00);
    step(); iRst = 1'b0; smp();
    check("post_rst_idle", oGrant, 2'b00);
    step(); smp();
    check("first_grant_m0", oGrant, 2'b01);
    check("first_m0_ack", {m1.ack, m0.ack}, 2'b01);
    step(); idle(3);

    // 2: M1 word write, then M0 read-back
    drv(1, 1'b1, 1'b1, 32'h10, 32'hDEAD_BEEF);
    smp();
    check("wr_req_idle", oGrant, 2'b00);
    step(); smp();
    check("wr_grant", oGrant, 2'b10);
    check("wr_s_we", s.we, 1);
    check("wr_s_addr", s.addr, 32'h10);
    check("wr_s_width", s.width, 2'b10);
    check("wr_s_data", s.data_write, 32'hDEAD_BEEF);
    check("wr_m1_ack", m1.ack, 1);
    check("wr_m0_quiet", {m0.ack, m0.data_read}, 33'd0);
    step(); idle(3);
    drv(0, 1'b1, 1'b0, 32'h10, 32'd0);
    step(); smp();
    check("rd_m0_ack", m0.ack, 1);
    check("rd_m0_data", m0.data_read, 32'hDEAD_BEEF);
    check("rd_m1_data0", m1.data_read, 32'd0);
    step(); drv(0, 1'b0, 1'b0, 32'd0, 32'd0); smp();
    check("rd_m0_ack_once", m0.ack, 0);
    idle(3);

    // 3: contention, four single-beat reads each, starting from reset
    iRst = 1'b1; step(); iRst = 1'b0; step();
    seq = '0; prev_g = 2'b11; n_ack = 0; bad_idle = 0; mon_en = 1'b1;
    fork
      run_master(0, 4, 32'h20);
      run_master(1, 4, 32'h80);
    join
    repeat (3) step();
    mon_en = 1'b0;
    exp_seq = '0;
    for (int k = 0; k < 4; k++) exp_seq = {exp_seq[55:0], 2'b01, 2'b00, 2'b10, 2'b00};
    check("cont_grant_seq", seq, exp_seq);
    check("cont_acks", n_ack, 8);
    check("cont_idle_side", bad_idle, 0);
    idle(2);

    // 4: M0 three-beat burst while M1 waits
    bad = 0;
    drv(0, 1'b1, 1'b0, 32'h0, 32'd0);
    drv(1, 1'b1, 1'b0, 32'h40, 32'd0);
    step(); smp();
    check("burst_grant", oGrant, 2'b01);
    check("burst_d0", m0.data_read, 32'hA000_0000); bad += m1.ack;
    step(); drv(0, 1'b1, 1'b0, 32'h4, 32'd0); smp();
    check("burst_d1", m0.data_read, 32'hA000_0001); bad += m1.ack;
    step(); drv(0, 1'b1, 1'b0, 32'h8, 32'd0); smp();
    check("burst_d2", m0.data_read, 32'hA000_0002); bad += m1.ack;
    step(); drv(0, 1'b0, 1'b0, 32'd0, 32'd0); smp(); bad += m1.ack;
    check("burst_hold_after_drop", oGrant, 2'b01);
    step(); smp(); bad += m1.ack;
    check("burst_release", oGrant, 2'b00);
    step(); smp(); bad += m1.ack;
    check("burst_idle", oGrant, 2'b00);
    step(); smp();
    check("burst_m1_grant", oGrant, 2'b10);
    check("burst_m1_data", m1.data_read, 32'hA000_0010);
    check("burst_m1_no_ack", bad, 0);
    step(); idle(3);

    // 5: watchdog on a stalled M1 read, M0 pending
    ack_en = 1'b0; bad = 0;
    drv(1, 1'b1, 1'b0, 32'h44, 32'd0);
    step();
    drv(0, 1'b1, 1'b0, 32'h0C, 32'd0);
    repeat (16) begin
      smp();
      if (oTimeout !== 1'b0 || oGrant !== 2'b10 || m1.ack !== 1'b0) bad++;
      step();
    end
    ack_en = 1'b1;
    smp();
    check("wdog_stall_window", bad, 0);
    check("wdog_pulse", oTimeout, 1);
    check("wdog_release", {oGrant, s.cyc}, 3'b000);
    step(); smp();
    check("wdog_pulse_end", oTimeout, 0);
    step(); smp();
    check("wdog_next_m0", oGrant, 2'b01);
    check("wdog_m0_data", m0.data_read, 32'hA000_0003);
    step(); idle(4);

    // 5b: ack arriving on the would-be timeout cycle
    ack_en = 1'b0;
    drv(0, 1'b1, 1'b0, 32'h48, 32'd0);
    repeat (16) step();
    ack_en = 1'b1;
    smp();
    check("late_ack", {m0.ack, m0.data_read}, {1'b1, 32'hA000_0012});
    step(); smp();
    check("late_ack_no_tmo", {oTimeout, oGrant}, 3'b001);
    idle(4);

    // 6: reset during a stalled M1 transfer
    ack_en = 1'b0;
    drv(1, 1'b1, 1'b0, 32'h4C, 32'd0);
    step(); smp();
    check("mid_grant", {oGrant, s.stb}, 3'b101);
    step(); iRst = 1'b1; drv(0, 1'b1, 1'b0, 32'h0, 32'd0); smp();
    check("mid_m1_ack", m1.ack, 0);
    step(); iRst = 1'b0; smp();
    check("mid_rst_drop", {s.cyc, oGrant, m1.ack}, 4'b0000);
    step(); smp();
    check("mid_tie_m0", oGrant, 2'b01);
    idle(3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
